tnet_tx_queue: RTL and testbench

Transmit-side packet builder and queue feeding the t-net Aurora link controller's transmit port. It accepts commands from the core, frames them into 128-bit t-net packets carrying the node's own ID, buffers them in a small FIFO, and presents them one at a time over the four-phase `tx_req`/`tx_dt`/`tx_ack` handshake. The controller runs on the Aurora user clock, so this block synchronizes every input it receives from the controller.

---
 rtl/tnet_tx_queue.sv | 139 +++++++++++++
 tb/tb_tnet_tx_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnet_tx_queue.sv
// Transmit-side packet framer and FIFO for the t-net Aurora link controller.
// Framed packets are handed to the controller over a four-phase req/ack handshake.
module tnet_tx_queue #(
    parameter int DEPTH       = 4,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               ID,
    input  logic                     link_ready_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [7:0]               s_op_i,
    input  logic [8:0]               s_dst_i,
    input  logic                     s_sync_i,
    input  logic [95:0]              s_dt_i,
    output logic                     tx_req_o,
    output logic [127:0]             tx_dt_o,
    input  logic                     tx_ack_i,
    output logic                     pkt_sent_o,
    output logic                     tx_timeout_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_e;

    logic [127:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_d;
    logic         ready_q, ready_d;
    logic         push, pop, empty;
    logic [1:0]   ack_sync_q, rdy_sync_q;
    logic         ack_s, rdy_s;
    state_e       state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [127:0] tx_dt_q, tx_dt_d, frame;
    logic         sent_q, sent_d, to_q, to_d;

    assign frame = {s_op_i, s_sync_i, 5'b0, s_dst_i, 1'b0, ID, s_dt_i};

    assign push     = s_valid_i & ready_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    assign cnt_d    = wr_ptr_d - rd_ptr_d;
    // Ready is registered so it stays low through reset and the first edge after it.
    assign ready_d  = (cnt_d != (AW+1)'(DEPTH));

    assign ack_s = ack_sync_q[1];
    assign rdy_s = rdy_sync_q[1];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= frame;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        tx_dt_d = tx_dt_q;
        sent_d  = 1'b0;
        to_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && rdy_s) begin
                    tx_dt_d = mem_q[rd_ptr_q[AW-1:0]];
                    pop     = 1'b1;
                    cyc_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cyc_q == CW'(SETUP_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = REQ;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            REQ: begin
                // Ack takes priority over a timeout expiring on the same edge.
                if (ack_s) begin
                    sent_d  = 1'b1;
                    state_d = RELEASE;
                end else if (TIMEOUT_CYC > 0 && cyc_q == CW'(TIMEOUT_CYC - 1)) begin
                    to_d    = 1'b1;
                    state_d = RELEASE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_q    <= 1'b0;
            ack_sync_q <= '0;
            rdy_sync_q <= '0;
            state_q    <= IDLE;
            cyc_q      <= '0;
            tx_dt_q    <= '0;
            sent_q     <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_q    <= ready_d;
            ack_sync_q <= {ack_sync_q[0], tx_ack_i};
            rdy_sync_q <= {rdy_sync_q[0], link_ready_i};
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            tx_dt_q    <= tx_dt_d;
            sent_q     <= sent_d;
            to_q       <= to_d;
        end
    end

    assign s_ready_o    = ready_q;
    assign tx_req_o     = (state_q == REQ);
    assign tx_dt_o      = tx_dt_q;
    assign pkt_sent_o   = sent_q;
    assign tx_timeout_o = to_q;
    assign fifo_cnt_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_tnet_tx_queue.sv
// Scoreboard bench for tnet_tx_queue: pushes directed packets, a monitor checks each
// presented packet in order, and the main sequence checks handshake timing.
module tb_tnet_tx_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0]   op;
        logic [8:0]   dst;
        logic         sync;
        logic [95:0]  dt;
        logic [127:0] exp;
    } vec_t;

    logic         clk;
    logic         rst_ni;
    logic         link_ready_i;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [7:0]   s_op_i;
    logic [8:0]   s_dst_i;
    logic         s_sync_i;
    logic [95:0]  s_dt_i;
    logic         tx_req_o;
    logic [127:0] tx_dt_o;
    logic         tx_ack_i;
    logic         pkt_sent_o;
    logic         tx_timeout_o;
    logic [2:0]   fifo_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    int sent_cnt = 0;
    int to_cnt = 0;
    int pkt_no = 0;
    logic req_prev = 1'b0;
    logic auto_ack = 1'b0;
    logic [127:0] exp_q [$];
    vec_t vecs [6];

    tnet_tx_queue #(.DEPTH(DEPTH), .SETUP_CYC(2), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .ID(8'h03), .link_ready_i(link_ready_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_op_i(s_op_i),
        .s_dst_i(s_dst_i), .s_sync_i(s_sync_i), .s_dt_i(s_dt_i),
        .tx_req_o(tx_req_o), .tx_dt_o(tx_dt_o), .tx_ack_i(tx_ack_i),
        .pkt_sent_o(pkt_sent_o), .tx_timeout_o(tx_timeout_o), .fifo_cnt_o(fifo_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the edge that accepted the command.
    task automatic push_vec(input int idx);
        int w = 0;
        s_valid_i = 1'b1;
        s_op_i    = vecs[idx].op;
        s_dst_i   = vecs[idx].dst;
        s_sync_i  = vecs[idx].sync;
        s_dt_i    = vecs[idx].dt;
        while (!s_ready_o && w < 200) begin
            tick(1);
            w++;
        end
        check("push_accept", {127'b0, s_ready_o}, 128'd1);
        tick(1);
        s_valid_i = 1'b0;
        exp_q.push_back(vecs[idx].exp);
    endtask

    task automatic drain(input int target);
        int w = 0;
        auto_ack = 1'b1;
        while (!(sent_cnt >= target && !tx_req_o && !tx_ack_i && fifo_cnt_o == 0) && w < 400) begin
            tick(1);
            w++;
        end
        tick(3);
        auto_ack = 1'b0;
        check("drain_sent", 128'(sent_cnt), 128'(target));
        check("drain_fifo", 128'(fifo_cnt_o), 128'd0);
    endtask

    // Controller model: ack follows req while enabled.
    initial forever begin
        @(posedge clk);
        #2;
        if (auto_ack) tx_ack_i = tx_req_o;
    end

    // Monitor: each rising request presents the next expected packet.
    always @(negedge clk) begin
        if (tx_req_o && !req_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", 128'd1, 128'd0);
            end else begin
                $display("pkt %0d presented: %h", pkt_no, tx_dt_o);
                check("pkt_data", tx_dt_o, exp_q.pop_front());
            end
            pkt_no <= pkt_no + 1;
        end
        req_prev <= tx_req_o;
        if (pkt_sent_o) sent_cnt <= sent_cnt + 1;
        if (tx_timeout_o) to_cnt <= to_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent0, to0;
        logic saw;
        vecs[0] = '{8'h12, 9'h005, 1'b1, 96'h0000000A_0000000B_0000000C,
                    128'h12800A03_0000000A_0000000B_0000000C};
        vecs[1] = '{8'hA5, 9'h1FF, 1'b0, 96'hDEADBEEF_01234567_89ABCDEF,
                    128'hA503FE03_DEADBEEF_01234567_89ABCDEF};
        vecs[2] = '{8'h00, 9'h000, 1'b1, 96'hFFFFFFFF_00000000_FFFFFFFF,
                    128'h00800003_FFFFFFFF_00000000_FFFFFFFF};
        vecs[3] = '{8'hFF, 9'h100, 1'b0, 96'h11111111_22222222_33333333,
                    128'hFF020003_11111111_22222222_33333333};
        vecs[4] = '{8'h3C, 9'h0AA, 1'b1, 96'h00000000_00000001_00000002,
                    128'h3C815403_00000000_00000001_00000002};
        vecs[5] = '{8'h81, 9'h001, 1'b0, 96'hCAFEF00D_0000FFFF_FFFF0000,
                    128'h81000203_CAFEF00D_0000FFFF_FFFF0000};

        rst_ni = 1'b0; link_ready_i = 1'b1; tx_ack_i = 1'b0; s_valid_i = 1'b0;
        s_op_i = '0; s_dst_i = '0; s_sync_i = 1'b0; s_dt_i = '0;
        #1;
        check("rst_ready", 128'(s_ready_o), 128'd0);
        check("rst_req", 128'(tx_req_o), 128'd0);
        check("rst_dt", tx_dt_o, 128'd0);
        check("rst_cnt", 128'(fifo_cnt_o), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        tick(1);
        check("ready_after_rst", 128'(s_ready_o), 128'd1);
        tick(4);

        // Single packet, exact timing.
        sent0 = sent_cnt;
        push_vec(0);                                   // E0+1
        check("t1_cnt_e0", 128'(fifo_cnt_o), 128'd1);
        tick(1);                                       // E1+1
        check("t1_dt_e1", tx_dt_o, 128'h12800A03_0000000A_0000000B_0000000C);
        check("t1_cnt_e1", 128'(fifo_cnt_o), 128'd0);
        tick(1);                                       // E2+1
        check("t1_req_e2", 128'(tx_req_o), 128'd0);
        tick(1);                                       // E3+1
        check("t1_req_e3", 128'(tx_req_o), 128'd1);
        tx_ack_i = 1'b1;
        tick(2);                                       // E5+1
        check("t1_req_e5", 128'(tx_req_o), 128'd1);
        check("t1_sent_e5", 128'(pkt_sent_o), 128'd0);
        tick(1);                                       // E6+1
        check("t1_req_e6", 128'(tx_req_o), 128'd0);
        check("t1_sent_e6", 128'(pkt_sent_o), 128'd1);
        tick(1);
        check("t1_sent_e7", 128'(pkt_sent_o), 128'd0);
        check("t1_dt_hold", tx_dt_o, 128'h12800A03_0000000A_0000000B_0000000C);
        tx_ack_i = 1'b0;
        tick(5);
        check("t1_sent_once", 128'(sent_cnt - sent0), 128'd1);

        // Five back-to-back pushes with ack withheld.
        sent0 = sent_cnt;
        for (int i = 1; i <= 5; i++) push_vec(i);
        check("t2_ready_full", 128'(s_ready_o), 128'd0);
        check("t2_cnt_full", 128'(fifo_cnt_o), 128'd4);
        drain(sent0 + 5);

        // Link not ready gates the start of transmission.
        link_ready_i = 1'b0;
        tick(3);
        sent0 = sent_cnt;
        push_vec(0);
        push_vec(3);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            saw = saw | tx_req_o;
        end
        check("t3_req_gated", 128'(saw), 128'd0);
        check("t3_cnt", 128'(fifo_cnt_o), 128'd2);
        link_ready_i = 1'b1;
        tick(4);                                       // L3+1
        check("t3_req_l3", 128'(tx_req_o), 128'd0);
        tick(1);                                       // L4+1
        check("t3_req_l4", 128'(tx_req_o), 128'd1);
        drain(sent0 + 2);

        // Timeout with no ack; next packet follows.
        sent0 = sent_cnt; to0 = to_cnt;
        push_vec(2);
        push_vec(4);                                   // E1+1
        tick(2);                                       // E3+1
        check("t4_req_e3", 128'(tx_req_o), 128'd1);
        tick(15);                                      // E18+1
        check("t4_to_e18", 128'(tx_timeout_o), 128'd0);
        check("t4_req_e18", 128'(tx_req_o), 128'd1);
        tick(1);                                       // E19+1
        check("t4_to_e19", 128'(tx_timeout_o), 128'd1);
        check("t4_req_e19", 128'(tx_req_o), 128'd0);
        check("t4_no_sent", 128'(pkt_sent_o), 128'd0);
        tick(3);                                       // E22+1
        check("t4_req_e22", 128'(tx_req_o), 128'd0);
        tick(1);                                       // E23+1
        check("t4_req_next", 128'(tx_req_o), 128'd1);
        drain(sent0 + 1);
        check("t4_to_once", 128'(to_cnt - to0), 128'd1);

        // Ack synchronized exactly on the timeout edge: ack wins.
        sent0 = sent_cnt; to0 = to_cnt;
        push_vec(5);                                   // E0+1
        tick(3);                                       // E3+1
        check("t5_req_e3", 128'(tx_req_o), 128'd1);
        tick(13);                                      // E16+1
        tx_ack_i = 1'b1;
        tick(2);                                       // E18+1
        check("t5_sent_e18", 128'(pkt_sent_o), 128'd0);
        check("t5_req_e18", 128'(tx_req_o), 128'd1);
        tick(1);                                       // E19+1
        check("t5_sent_e19", 128'(pkt_sent_o), 128'd1);
        check("t5_to_e19", 128'(tx_timeout_o), 128'd0);
        check("t5_req_e19", 128'(tx_req_o), 128'd0);
        tick(1);
        tx_ack_i = 1'b0;
        tick(5);
        check("t5_to_none", 128'(to_cnt - to0), 128'd0);
        check("t5_sent_once", 128'(sent_cnt - sent0), 128'd1);

        // Reset mid-handshake with three packets queued.
        for (int i = 1; i <= 4; i++) push_vec(i);      // E3+1
        check("t6_cnt_pre", 128'(fifo_cnt_o), 128'd3);
        check("t6_req_pre", 128'(tx_req_o), 128'd1);
        rst_ni = 1'b0;
        #1;
        check("t6_req_rst", 128'(tx_req_o), 128'd0);
        check("t6_dt_rst", tx_dt_o, 128'd0);
        check("t6_cnt_rst", 128'(fifo_cnt_o), 128'd0);
        check("t6_ready_rst", 128'(s_ready_o), 128'd0);
        check("t6_pulses_rst", 128'({pkt_sent_o, tx_timeout_o}), 128'd0);
        exp_q.delete();
        tick(2);
        rst_ni = 1'b1;
        check("t6_ready_rel", 128'(s_ready_o), 128'd0);
        tick(1);
        check("t6_ready_edge", 128'(s_ready_o), 128'd1);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            saw = saw | tx_req_o;
        end
        check("t6_no_stale_req", 128'(saw), 128'd0);
        check("t6_cnt_post", 128'(fifo_cnt_o), 128'd0);
        sent0 = sent_cnt;
        push_vec(0);
        drain(sent0 + 1);

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
